pwm_capture: RTL and testbench

PWM input-capture peripheral: the receive-side counterpart to the PWM generator on the same CPU bus. It samples an external PWM waveform, measures high time and period in clock cycles, and exposes both plus status to the CPU through the bSel/bWrite/bWData/bRData slave interface. Typical uses are loopback test of the PWM generator and reading external duty-cycle sensors.

---
 rtl/pwm_capture_pkg.sv | 23 ++
 rtl/pwm_capture_sync_2ff.sv | 22 ++
 rtl/pwm_capture.sv | 147 ++++++++++++++
 tb/tb_pwm_capture.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM input-capture peripheral.
package pwm_capture_pkg;

    // Measurement phases of the capture engine.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } captureState;

    // CPU-visible register addresses.
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_HIGH   = 2'd1;
    localparam logic [1:0] ADDR_PERIOD = 2'd2;

    // CTRL register bit positions.
    localparam int EN    = 0;
    localparam int VALID = 1;
    localparam int OVF   = 2;
    localparam int LEVEL = 3;

endpackage

// File: rtl/pwm_capture_sync_2ff.sv
// Two-stage synchronizer for a single asynchronous input, cleared by reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic asyncIn,
    output logic syncOut
);

    logic metaStage;

    // Shift the async input through two flops to settle metastability.
    always_ff @(posedge clk) begin
        if (!rst) begin
            metaStage <= 1'b0;
            syncOut   <= 1'b0;
        end else begin
            metaStage <= asyncIn;
            syncOut   <= metaStage;
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// PWM input capture: measures high time and period of an external waveform
// in clk cycles and exposes them through a small CPU register interface.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bSel,
    input  logic        bWrite,
    input  logic [1:0]  bAddr,
    input  logic [31:0] bWData,
    output logic [31:0] bRData,
    input  logic        pwmInput,
    output logic        capValid
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic             syncLevel;
    logic             prevLevel;
    logic             rise;
    logic             fall;
    logic             ctrlWrite;
    captureState      state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] hiShadow;
    logic [WIDTH-1:0] highTime;
    logic [WIDTH-1:0] periodTime;
    logic             enBit;
    logic             validBit;
    logic             ovfBit;
    logic             cntFull;
    logic             setValid;
    logic             setOvf;
    logic             unusedWData;

    sync_2ff uSync (
        .clk     (clk),
        .rst     (rst),
        .asyncIn (pwmInput),
        .syncOut (syncLevel)
    );

    // One-cycle delayed copy of the synchronized level for edge detection.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prevLevel <= 1'b0;
        end else begin
            prevLevel <= syncLevel;
        end
    end

    assign rise        = syncLevel & ~prevLevel;
    assign fall        = ~syncLevel & prevLevel;
    assign ctrlWrite   = bSel & bWrite & (bAddr == ADDR_CTRL);
    assign unusedWData = ^bWData[31:3];

    // Status events raised by the measurement engine this cycle.
    always_comb begin
        cntFull  = (cnt == CNT_MAX);
        setValid = enBit && (state == LOW) && rise;
        setOvf   = enBit && cntFull &&
                   (((state == HIGH) && !fall) || ((state == LOW) && !rise));
    end

    // Measurement FSM with cycle counter and result registers. IDLE with en
    // already set behaves like ARM so a rise right after enabling is not lost.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            hiShadow   <= '0;
            highTime   <= '0;
            periodTime <= '0;
        end else if (!enBit) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            if (rise) begin
                cnt <= CNT_ONE;
            end else if (!cntFull) begin
                cnt <= cnt + CNT_ONE;
            end
            case (state)
                IDLE, ARM: begin
                    state <= rise ? HIGH : ARM;
                end
                HIGH: begin
                    if (fall) begin
                        hiShadow <= cnt;
                        state    <= LOW;
                    end else if (cntFull) begin
                        state <= ARM;
                    end
                end
                LOW: begin
                    if (rise) begin
                        highTime   <= hiShadow;
                        periodTime <= cnt;
                        state      <= HIGH;
                    end else if (cntFull) begin
                        state <= ARM;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // CTRL flags: en is plain RW; valid/ovf are set by hardware, W1C by CPU,
    // and a hardware set in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            enBit    <= 1'b0;
            validBit <= 1'b0;
            ovfBit   <= 1'b0;
        end else begin
            if (ctrlWrite) begin
                enBit <= bWData[EN];
            end
            validBit <= setValid | (validBit & ~(ctrlWrite & bWData[VALID]));
            ovfBit   <= setOvf | (ovfBit & ~(ctrlWrite & bWData[OVF]));
        end
    end

    // Combinational read mux, independent of bSel.
    always_comb begin
        bRData = '0;
        case (bAddr)
            ADDR_CTRL: begin
                bRData[EN]    = enBit;
                bRData[VALID] = validBit;
                bRData[OVF]   = ovfBit;
                bRData[LEVEL] = syncLevel;
            end
            ADDR_HIGH:   bRData[WIDTH-1:0] = highTime;
            ADDR_PERIOD: bRData[WIDTH-1:0] = periodTime;
            default:     bRData = '0;
        endcase
    end

    assign capValid = validBit;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: directed scenarios plus randomized PWM traffic,
// checked every cycle against a timestamp-based model of the measurement.
module tb_pwm_capture;

    localparam int WIDTH  = 9;
    localparam int ALLONE = (1 << WIDTH) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        bSel = 1'b0;
    logic        bWrite = 1'b0;
    logic [1:0]  bAddr = 2'd0;
    logic [31:0] bWData = 32'd0;
    logic [31:0] bRData;
    logic        pwmInput = 1'b0;
    logic        capValid;

    int checks = 0;
    int failures = 0;

    pwm_capture #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .bSel     (bSel),
        .bWrite   (bWrite),
        .bAddr    (bAddr),
        .bWData   (bWData),
        .bRData   (bRData),
        .pwmInput (pwmInput),
        .capValid (capValid)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Tracks the synchronized level and the timestamps of the reference rise
    // and of the falling edge; results are differences of edge times.
    int  cyc = 0;
    bit  modelLive = 0;
    bit  s1M, syncM, prevM;
    bit  mEn, mValid, mOvf;
    bit  haveRef, haveFall;
    int  riseEdge, hiLen, mHigh, mPeriod;
    bit  riseM, fallM, setV, setO, wrM;

    always @(posedge clk) begin
        if (!rst) begin
            s1M = 0; syncM = 0; prevM = 0;
            mEn = 0; mValid = 0; mOvf = 0;
            haveRef = 0; haveFall = 0;
            riseEdge = 0; hiLen = 0; mHigh = 0; mPeriod = 0;
            modelLive = 1;
        end else begin
            riseM = syncM & ~prevM;
            fallM = ~syncM & prevM;
            setV = 0;
            setO = 0;
            if (!mEn) begin
                haveRef = 0;
                haveFall = 0;
            end else if (!haveRef) begin
                if (riseM) begin
                    haveRef = 1; haveFall = 0; riseEdge = cyc;
                end
            end else if (!haveFall) begin
                if (fallM) begin
                    haveFall = 1; hiLen = cyc - riseEdge;
                end else if (cyc - riseEdge >= ALLONE) begin
                    setO = 1; haveRef = 0;
                end
            end else begin
                if (riseM) begin
                    mHigh = hiLen; mPeriod = cyc - riseEdge; setV = 1;
                    riseEdge = cyc; haveFall = 0;
                end else if (cyc - riseEdge >= ALLONE) begin
                    setO = 1; haveRef = 0; haveFall = 0;
                end
            end
            wrM    = bSel && bWrite && (bAddr == 2'd0);
            mValid = setV | (mValid & ~(wrM & bWData[1]));
            mOvf   = setO | (mOvf & ~(wrM & bWData[2]));
            if (wrM) mEn = bWData[0];
            prevM = syncM;
            syncM = s1M;
            s1M   = pwmInput;
        end
        cyc++;
    end

    // Compare the visible register and interrupt line every cycle.
    logic [31:0] expRd;
    always @(negedge clk) begin
        if (modelLive) begin
            case (bAddr)
                2'd0:    expRd = {28'd0, syncM, mOvf, mValid, mEn};
                2'd1:    expRd = 32'(mHigh);
                2'd2:    expRd = 32'(mPeriod);
                default: expRd = 32'd0;
            endcase
            checks++;
            if (bRData !== expRd) begin
                failures++;
                $display("FAIL model_rdata cyc=%0d addr=%0d got=%h exp=%h", cyc, bAddr, bRData, expRd);
            end
            checks++;
            if (capValid !== mValid) begin
                failures++;
                $display("FAIL model_capValid cyc=%0d got=%b exp=%b", cyc, capValid, mValid);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    bit pwmLevel = 0;

    task automatic tick(input bit wr, input logic [1:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        if (wr) begin
            bSel = 1'b1; bWrite = 1'b1;
        end else begin
            bSel = 1'($urandom_range(0, 1));
            bWrite = bSel ? 1'b0 : 1'($urandom_range(0, 1));
        end
        bAddr = a;
        bWData = d;
        pwmInput = pwmLevel;
    endtask

    task automatic writeCtrl(input logic [31:0] d);
        tick(1'b1, 2'd0, d);
        $display("write CTRL=%h", d);
    endtask

    task automatic drive(input bit level, input int n, input bit randWrites);
        logic [31:0] d;
        pwmLevel = level;
        for (int i = 0; i < n; i++) begin
            if (randWrites && $urandom_range(0, 19) == 0) begin
                d = $urandom;
                if ($urandom_range(0, 7) != 0) d[0] = 1'b1;
                tick(1'b1, 2'($urandom_range(0, 3)), d);
            end else begin
                tick(1'b0, 2'($urandom_range(0, 3)), $urandom);
            end
        end
    endtask

    task automatic expectReg(input string name, input logic [1:0] a, input logic [31:0] exp);
        tick(1'b0, a, $urandom);
        @(negedge clk);
        checks++;
        if (bRData !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, bRData, exp);
        end else begin
            $display("read %s addr=%0d data=%h", name, a, bRData);
        end
    endtask

    task automatic expectFlag(input string name, input logic exp);
        @(negedge clk);
        checks++;
        if (capValid !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", name, capValid, exp);
        end else begin
            $display("flag %s capValid=%b", name, capValid);
        end
    endtask

    function automatic int randLen();
        if ($urandom_range(0, 19) == 0) return 520;
        return int'($urandom_range(1, 40));
    endfunction

    // ---------------- scenario ----------------
    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        expectFlag("reset_capValid", 1'b0);
        expectReg("reset_ctrl", 2'd0, 32'h0);
        expectReg("reset_high", 2'd1, 32'h0);
        expectReg("reset_period", 2'd2, 32'h0);

        // Basic 30/70 capture
        writeCtrl(32'h1);
        for (int p = 0; p < 3; p++) begin
            drive(1, 30, 0);
            drive(0, 70, 0);
        end
        expectReg("basic_high", 2'd1, 32'd30);
        expectReg("basic_period", 2'd2, 32'd100);
        expectReg("basic_ctrl", 2'd0, 32'h3);
        writeCtrl(32'h3);
        expectReg("w1c_valid_ctrl", 2'd0, 32'h1);
        drive(1, 30, 0);
        expectFlag("valid_reassert", 1'b1);
        drive(0, 70, 0);

        // Generator loopback 192/64, then a stuck-high input
        for (int p = 0; p < 3; p++) begin
            drive(1, 192, 0);
            drive(0, 64, 0);
        end
        drive(1, 600, 0);
        expectReg("loop_high", 2'd1, 32'd192);
        expectReg("loop_period", 2'd2, 32'd256);
        expectReg("ovf_ctrl", 2'd0, 32'hF);

        // Recovery after overflow with 10/10
        drive(0, 10, 0);
        for (int p = 0; p < 3; p++) begin
            drive(1, 10, 0);
            drive(0, 10, 0);
        end
        expectReg("recov_high", 2'd1, 32'd10);
        expectReg("recov_period", 2'd2, 32'd20);
        expectReg("recov_ctrl", 2'd0, 32'h7);
        writeCtrl(32'h5);
        expectReg("ovf_clear_ctrl", 2'd0, 32'h3);

        // W1C of valid on the very edge that completes a measurement
        writeCtrl(32'h3);
        expectReg("pre_simul_ctrl", 2'd0, 32'h1);
        pwmLevel = 1;
        tick(1'b0, 2'd1, 32'd0);
        tick(1'b0, 2'd2, 32'd0);
        writeCtrl(32'h3);
        expectReg("simul_ctrl", 2'd0, 32'hB);
        drive(1, 10, 0);

        // Disable mid-HIGH, re-enable: first result needs two rises
        writeCtrl(32'h2);
        expectReg("disable_high_kept", 2'd1, 32'd10);
        expectReg("disable_ctrl", 2'd0, 32'h8);
        writeCtrl(32'h1);
        drive(1, 5, 0);
        drive(0, 25, 0);
        drive(1, 15, 0);
        expectFlag("reenable_one_rise", 1'b0);
        drive(0, 25, 0);
        drive(1, 15, 0);
        expectFlag("reenable_two_rises", 1'b1);
        drive(0, 20, 0);
        expectReg("reenable_high", 2'd1, 32'd15);
        expectReg("reenable_period", 2'd2, 32'd40);

        // Randomized phases and register traffic
        writeCtrl(32'h1);
        for (int p = 0; p < 60; p++) begin
            drive(1, randLen(), 1);
            drive(0, randLen(), 1);
        end

        // Reset while in the LOW phase
        writeCtrl(32'h1);
        drive(0, 10, 0);
        drive(1, 20, 0);
        drive(0, 10, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        expectFlag("rst_low_capValid", 1'b0);
        expectReg("rst_low_ctrl", 2'd0, 32'h0);
        expectReg("rst_low_high", 2'd1, 32'h0);
        expectReg("rst_low_period", 2'd2, 32'h0);
        expectReg("reserved_addr", 2'd3, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
